// File: rtl/cam_bringup_seq.sv
// Camera bring-up sequencer: power enable -> I2C reset release -> I2C config -> CSI enable.
// Define CAM_SEQ_RETRY_EN to build the power-cycle retry path (COOL state, retry_cnt).
module cam_bringup_seq #(
   parameter int T_PWR     = 4000,
   parameter int T_I2CRST  = 400,
   parameter int T_CFG_TO  = 400000,
   parameter int T_OFF     = 4000,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk_100,
   input  logic       reset,
   input  logic       strobe_400kHz,
   input  logic       idelay_rdy,
   input  logic       i2c_done,
   input  logic       i2c_err,
   input  logic       restart,
   output logic       cam_en,
   output logic       i2c_areset_n,
   output logic       i2c_start,
   output logic       csi_en,
   output logic       link_up,
   output logic       fault,
   output logic [1:0] retry_cnt
);

`ifdef CAM_SEQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam logic [19:0] PWR_LAST    = 20'(T_PWR - 1);
   localparam logic [19:0] I2CRST_LAST = 20'(T_I2CRST - 1);
   localparam logic [19:0] CFG_LAST    = 20'(T_CFG_TO - 1);
   localparam logic [19:0] OFF_LAST    = 20'(T_OFF - 1);
   localparam logic [1:0]  MAX_RETRY_C = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_OFF, S_PWR_WAIT, S_RST_WAIT, S_CFG, S_DLY_WAIT, S_UP, S_COOL, S_FAULT
   } state_t;

   state_t      state;
   logic [19:0] tick_cnt;

   // A timed state expires on the strobe cycle that completes its tick budget.
   function automatic logic expired(input logic [19:0] last);
      return strobe_400kHz && (tick_cnt == last);
   endfunction

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         state        <= S_OFF;
         tick_cnt     <= '0;
         retry_cnt    <= '0;
         cam_en       <= 1'b0;
         i2c_areset_n <= 1'b0;
         i2c_start    <= 1'b0;
         csi_en       <= 1'b0;
         link_up      <= 1'b0;
         fault        <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; the defaults below are overridden by any later
         // assignment in the case arms, which is how the counter clears on state entry.
         i2c_start <= 1'b0;
         if (strobe_400kHz)
            tick_cnt <= tick_cnt + 20'd1;

         case (state)
            S_OFF: begin
               if (strobe_400kHz) begin
                  state    <= S_PWR_WAIT;
                  tick_cnt <= '0;
                  cam_en   <= 1'b1;
               end
            end
            S_PWR_WAIT: begin
               if (expired(PWR_LAST)) begin
                  state        <= S_RST_WAIT;
                  tick_cnt     <= '0;
                  i2c_areset_n <= 1'b1;
               end
            end
            S_RST_WAIT: begin
               if (expired(I2CRST_LAST)) begin
                  state     <= S_CFG;
                  tick_cnt  <= '0;
                  i2c_start <= 1'b1;
               end
            end
            S_CFG: begin
               if (i2c_err || (!i2c_done && expired(CFG_LAST))) begin
                  tick_cnt     <= '0;
                  cam_en       <= 1'b0;
                  i2c_areset_n <= 1'b0;
                  if (RETRY_EN && (retry_cnt < MAX_RETRY_C)) begin
                     state     <= S_COOL;
                     retry_cnt <= retry_cnt + 2'd1;
                  end else begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                  end
               end else if (i2c_done) begin
                  tick_cnt <= '0;
                  // With IDELAYCTRL already locked, skip the wait so csi_en follows done by one clock.
                  if (idelay_rdy) begin
                     state   <= S_UP;
                     csi_en  <= 1'b1;
                     link_up <= 1'b1;
                  end else begin
                     state <= S_DLY_WAIT;
                  end
               end
            end
            S_DLY_WAIT: begin
               if (idelay_rdy) begin
                  state    <= S_UP;
                  tick_cnt <= '0;
                  csi_en   <= 1'b1;
                  link_up  <= 1'b1;
               end
            end
            S_COOL: begin
               if (expired(OFF_LAST)) begin
                  state    <= S_PWR_WAIT;
                  tick_cnt <= '0;
                  cam_en   <= 1'b1;
               end
            end
            S_UP, S_FAULT: begin
               if (restart) begin
                  state        <= S_OFF;
                  tick_cnt     <= '0;
                  retry_cnt    <= '0;
                  cam_en       <= 1'b0;
                  i2c_areset_n <= 1'b0;
                  csi_en       <= 1'b0;
                  link_up      <= 1'b0;
                  fault        <= 1'b0;
               end
            end
            default: begin
               state    <= S_OFF;
               tick_cnt <= '0;
            end
         endcase
      end
   end

endmodule
